// File: rtl/sonic_obstacle_guard.sv
// Obstacle guard: stable-capture sampler, 4-deep moving average, and a debounced
// CRUISE/SLOW/BLOCKED FSM that drives the motor enables and PWM outputs.
module sonic_obstacle_guard #(
  parameter int SAMPLE_CYCLES = 10000000,
  parameter int STOP_CM       = 12,
  parameter int RESUME_CM     = 20,
  parameter int SLOW_CM       = 40,
  parameter int SLOW_HYST     = 5,
  parameter int CONFIRM       = 2,
  parameter int DUTY_FAST     = 255,
  parameter int DUTY_SLOW     = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] distance,
  input  logic        start_move,
  input  logic        start_left_move,
  input  logic        start_right_move,
  output logic        en_left,
  output logic        en_right,
  output logic        pwm_left,
  output logic        pwm_right,
  output logic [1:0]  state,
  output logic [9:0]  avg_cm,
  output logic        sample_pulse
);

  typedef enum logic [1:0] {
    CRUISE  = 2'b00,
    SLOW    = 2'b01,
    BLOCKED = 2'b10
  } state_t;

  localparam int             TW       = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [TW-1:0]  TC       = TW'(SAMPLE_CYCLES - 1);
  localparam logic [9:0]     STOP_V   = 10'(STOP_CM);
  localparam logic [9:0]     RESUME_V = 10'(RESUME_CM);
  localparam logic [9:0]     SLOW_V   = 10'(SLOW_CM);
  localparam logic [10:0]    CLEAR_V  = 11'(SLOW_CM + SLOW_HYST);
  localparam logic [3:0]     CONF_V   = 4'(CONFIRM);
  localparam logic [7:0]     FAST_D   = 8'(DUTY_FAST);
  localparam logic [7:0]     SLOW_D   = 8'(DUTY_SLOW);

  logic [19:0]      dist_q;
  logic [TW-1:0]    timer;
  logic             first;
  logic [3:0][9:0]  win;
  logic [11:0]      sum;
  logic             eval;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty;
  logic [3:0]       cnt_q, cnt_d, cnt_inc;
  state_t           state_q, state_d;
  logic             capture;
  logic [9:0]       value;

  // Capture only when the input has been stable for one cycle at the terminal count.
  assign capture = (timer == TC) && (distance == dist_q);
  assign value   = (dist_q > 20'd1023) ? 10'd1023 : dist_q[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_q       <= '0;
      timer        <= '0;
      first        <= 1'b1;
      win          <= '0;
      sum          <= '0;
      avg_cm       <= '0;
      sample_pulse <= 1'b0;
      eval         <= 1'b0;
      pwm_cnt      <= '0;
    end else begin
      dist_q       <= distance;
      pwm_cnt      <= pwm_cnt + 8'd1;
      sample_pulse <= capture;
      eval         <= sample_pulse;
      avg_cm       <= sum[11:2];
      if (capture) begin
        timer <= '0;
        first <= 1'b0;
        if (first) begin
          win <= {4{value}};
          sum <= {value, 2'b00};
        end else begin
          win <= {win[2:0], value};
          sum <= sum + 12'(value) - 12'(win[3]);
        end
      end else if (timer != TC) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (eval) begin
      unique case (state_q)
        CRUISE, SLOW: begin
          if (avg_cm <= STOP_V) begin
            if (cnt_inc == CONF_V) begin
              state_d = BLOCKED;
              cnt_d   = '0;
            end else begin
              state_d = SLOW;
              cnt_d   = cnt_inc;
            end
          end else begin
            cnt_d = '0;
            if (state_q == CRUISE && avg_cm < SLOW_V)
              state_d = SLOW;
            else if (state_q == SLOW && {1'b0, avg_cm} >= CLEAR_V)
              state_d = CRUISE;
          end
        end
        BLOCKED: begin
          if (avg_cm >= RESUME_V) begin
            if (cnt_inc == CONF_V) begin
              state_d = SLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = BLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign en_left   = (state_q != BLOCKED) & (start_move | start_left_move);
  assign en_right  = (state_q != BLOCKED) & (start_move | start_right_move);
  assign duty      = (state_q == CRUISE) ? FAST_D : (state_q == SLOW) ? SLOW_D : '0;
  assign pwm_left  = en_left  & (pwm_cnt < duty);
  assign pwm_right = en_right & (pwm_cnt < duty);

endmodule
